// File: rtl/sys_pkg.sv
// Shared types and constants for the ibus transfer engine.
// Holds the FSM state encoding, bus widths and direction codes.
package sys_pkg;

    localparam int IBUS_AW = 14;
    localparam int DATA_W  = 16;

    localparam logic DIR_LOAD  = 1'b0;
    localparam logic DIR_STORE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MRD,
        ST_IBWR,
        ST_IBRD,
        ST_IBCAP,
        ST_MWR,
        ST_FIN
    } xfer_state_e;

endpackage

// File: rtl/xfer_addr_gen.sv
// Paired ibus/memory word pointers plus remaining-word down-counter.
// Shared by the load path and the result-drain path.
module xfer_addr_gen
    import sys_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int CNT_W  = 14
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [IBUS_AW-1:0] ibus_base_i,
    input  logic [MEM_AW-1:0]  mem_base_i,
    input  logic [CNT_W-1:0]   len_i,
    output logic [IBUS_AW-1:0] ibus_ptr_o,
    output logic [MEM_AW-1:0]  mem_ptr_o,
    output logic               last_o
);

    logic [IBUS_AW-1:0] ibus_ptr_q;
    logic [MEM_AW-1:0]  mem_ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    // Pointers wrap naturally at their own widths.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ibus_ptr_q <= '0;
            mem_ptr_q  <= '0;
            cnt_q      <= '0;
        end else if (load_i) begin
            ibus_ptr_q <= ibus_base_i;
            mem_ptr_q  <= mem_base_i;
            cnt_q      <= len_i;
        end else if (step_i) begin
            ibus_ptr_q <= ibus_ptr_q + 1'b1;
            mem_ptr_q  <= mem_ptr_q + 1'b1;
            cnt_q      <= cnt_q - 1'b1;
        end
    end

    assign ibus_ptr_o = ibus_ptr_q;
    assign mem_ptr_o  = mem_ptr_q;
    assign last_o     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ibus_xfer_master.sv
// Word-at-a-time bus master moving data between system memory
// and the systolic array buffer RAM port in either direction.
module ibus_xfer_master
    import sys_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int CNT_W  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir,
    input  logic [IBUS_AW-1:0] ibus_base,
    input  logic [MEM_AW-1:0]  mem_base,
    input  logic [CNT_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               ibus_ren,
    output logic [IBUS_AW-1:0] ibus_radr,
    input  logic [DATA_W-1:0]  ibus_rdata,
    output logic               ibus_wen,
    output logic [IBUS_AW-1:0] ibus_wadr,
    output logic [DATA_W-1:0]  ibus_wdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MEM_AW-1:0]  mem_adr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack
);

    xfer_state_e        state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               busy_q, done_q;
    logic               ren_q, wen_q;
    logic               req_q, we_q;
    logic               load, step, last, ack;
    logic [IBUS_AW-1:0] ibus_ptr;
    logic [MEM_AW-1:0]  mem_ptr;

    xfer_addr_gen #(
        .MEM_AW (MEM_AW),
        .CNT_W  (CNT_W)
    ) u_addr (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (load),
        .step_i      (step),
        .ibus_base_i (ibus_base),
        .mem_base_i  (mem_base),
        .len_i       (len),
        .ibus_ptr_o  (ibus_ptr),
        .mem_ptr_o   (mem_ptr),
        .last_o      (last)
    );

    // Acks arriving without an outstanding request are dropped.
    assign ack = req_q && mem_ack;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0)
                        state_d = ST_FIN;
                    else if (dir == DIR_STORE)
                        state_d = ST_IBRD;
                    else
                        state_d = ST_MRD;
                end
            end
            ST_MRD: begin
                if (ack) begin
                    data_d  = mem_rdata;
                    state_d = ST_IBWR;
                end
            end
            ST_IBWR: begin
                step    = 1'b1;
                state_d = last ? ST_FIN : ST_MRD;
            end
            ST_IBRD: state_d = ST_IBCAP;
            ST_IBCAP: begin
                data_d  = ibus_rdata;
                state_d = ST_MWR;
            end
            ST_MWR: begin
                if (ack) begin
                    step    = 1'b1;
                    state_d = last ? ST_FIN : ST_IBRD;
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_FIN);
            done_q  <= (state_d == ST_FIN);
            ren_q   <= (state_d == ST_IBRD);
            wen_q   <= (state_d == ST_IBWR);
            req_q   <= (state_d == ST_MRD) || (state_d == ST_MWR);
            we_q    <= (state_d == ST_MWR);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ibus_ren   = ren_q;
    assign ibus_radr  = ibus_ptr;
    assign ibus_wen   = wen_q;
    assign ibus_wadr  = ibus_ptr;
    assign ibus_wdata = data_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_adr    = mem_ptr;
    assign mem_wdata  = data_q;

endmodule

// File: tb/tb_ibus_xfer_master.sv
// Bench for ibus_xfer_master: memory/buffer models, a transfer-level
// reference model and directed plus randomized traffic.
module tb_ibus_xfer_master;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dir;
    logic [13:0] ibus_base;
    logic [15:0] mem_base;
    logic [13:0] len;
    logic        busy;
    logic        done;
    logic        ibus_ren;
    logic [13:0] ibus_radr;
    logic [15:0] ibus_rdata;
    logic        ibus_wen;
    logic [13:0] ibus_wadr;
    logic [15:0] ibus_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    ibus_xfer_master #(
        .MEM_AW (16),
        .CNT_W  (14)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir        (dir),
        .ibus_base  (ibus_base),
        .mem_base   (mem_base),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ibus_ren   (ibus_ren),
        .ibus_radr  (ibus_radr),
        .ibus_rdata (ibus_rdata),
        .ibus_wen   (ibus_wen),
        .ibus_wadr  (ibus_wadr),
        .ibus_wdata (ibus_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem_a  [0:65535];
    logic [15:0] ibuf_a [0:16383];

    int errors = 0;
    int checks = 0;

    int fixed_lat = 1;
    bit rand_ack  = 1'b0;

    int done_cnt   = 0;
    int busy_cnt   = 0;
    int ren_cnt    = 0;
    int strobe_cnt = 0;

    // reference model state
    bit          m_busy    = 1'b0;
    bit          done_now  = 1'b0;
    bit          m_dir     = 1'b0;
    bit          zero_next = 1'b0;
    int          nxt       = 0;
    logic [13:0] q_ibw_a [$];
    logic [15:0] q_ibw_d [$];
    logic [15:0] q_mrd   [$];
    logic [13:0] q_ibr   [$];
    logic [15:0] q_mw_a  [$];
    logic [15:0] q_mw_d  [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: actual=event required=no event", nm);
    endtask

    // ibus read port: data valid the cycle after the strobe
    initial begin
        logic        ren_s;
        logic [13:0] radr_s;
        ren_s      = 1'b0;
        radr_s     = '0;
        ibus_rdata = '0;
        fork
            forever begin
                @(negedge clk);
                ren_s  = ibus_ren;
                radr_s = ibus_radr;
            end
            forever begin
                @(posedge clk);
                #1;
                ibus_rdata = ren_s ? ibuf_a[radr_s] : 16'($urandom);
            end
        join
    end

    // system memory responder with variable latency
    initial begin
        int mcnt;
        int cur_lat;
        mcnt      = 0;
        cur_lat   = 1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                mcnt      = 0;
                mem_ack   = !rst && rand_ack && ($urandom_range(0, 7) == 0);
                mem_rdata = 16'($urandom);
            end else begin
                if (mcnt == 0)
                    cur_lat = (fixed_lat > 0) ? fixed_lat
                                              : int'($urandom_range(1, 4));
                mcnt++;
                if (mcnt >= cur_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? 16'($urandom) : mem_a[mem_adr];
                    mcnt      = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'($urandom);
                end
            end
        end
    end

    // compare process: one evaluation per cycle
    initial begin
        bit          last;
        bit          idle_now;
        bit          busy_nx;
        bit          done_nx;
        int          nxt_n;
        logic [13:0] ia;
        logic [15:0] ma;
        logic [15:0] dv;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                q_ibw_a.delete();
                q_ibw_d.delete();
                q_mrd.delete();
                q_ibr.delete();
                q_mw_a.delete();
                q_mw_d.delete();
                m_busy    = 1'b0;
                done_now  = 1'b0;
                nxt       = 0;
                zero_next = 1'b1;
            end else begin
                if (zero_next) begin
                    chk("reset_ctrl",
                        {busy, done, ibus_ren, ibus_wen, mem_req, mem_we}, 0);
                    chk("reset_addr", {ibus_radr, ibus_wadr, mem_adr}, 0);
                    chk("reset_wdata", {ibus_wdata, mem_wdata}, 0);
                    zero_next = 1'b0;
                end
                last = 1'b0;
                chk("busy", busy, m_busy);
                chk("done", done, done_now);
                chk("ren_wen_excl", ibus_ren & ibus_wen, 0);
                if (!m_busy)
                    chk("idle_quiet", {mem_req, ibus_ren, ibus_wen}, 0);
                case (nxt)
                    1: chk("ibwr_after_ack", ibus_wen, 1);
                    2: chk("req_in_time", mem_req, 1);
                    3: chk("ren_in_time", ibus_ren, 1);
                    4: chk("ibcap_gap", {mem_req, ibus_ren, ibus_wen}, 0);
                    default: ;
                endcase
                nxt_n = (nxt == 4) ? 2 : 0;
                if (ibus_ren) ren_cnt++;
                if (mem_req || ibus_ren || ibus_wen) strobe_cnt++;
                if (busy) busy_cnt++;
                if (done) done_cnt++;
                if (m_busy) begin
                    if (ibus_wen) begin
                        ibuf_a[ibus_wadr] = ibus_wdata;
                        if (m_dir != 1'b0 || q_ibw_a.size() == 0) begin
                            fail("ibus_write_unexpected");
                        end else begin
                            chk("ibus_wadr", ibus_wadr, q_ibw_a[0]);
                            chk("ibus_wdata", ibus_wdata, q_ibw_d[0]);
                            ia = q_ibw_a.pop_front();
                            dv = q_ibw_d.pop_front();
                            if (q_ibw_a.size() == 0) last = 1'b1;
                            else nxt_n = 2;
                        end
                    end
                    if (mem_req && !mem_we) begin
                        if (m_dir != 1'b0 || q_mrd.size() == 0) begin
                            fail("mem_read_unexpected");
                        end else begin
                            chk("mem_radr", mem_adr, q_mrd[0]);
                            if (mem_ack) begin
                                ma    = q_mrd.pop_front();
                                nxt_n = 1;
                            end
                        end
                    end
                    if (mem_req && mem_we) begin
                        if (m_dir != 1'b1 || q_mw_a.size() == 0) begin
                            fail("mem_write_unexpected");
                        end else begin
                            chk("mem_wadr", mem_adr, q_mw_a[0]);
                            chk("mem_wdata", mem_wdata, q_mw_d[0]);
                            if (mem_ack) begin
                                mem_a[mem_adr] = mem_wdata;
                                ma = q_mw_a.pop_front();
                                dv = q_mw_d.pop_front();
                                if (q_mw_a.size() == 0) last = 1'b1;
                                else nxt_n = 3;
                            end
                        end
                    end
                    if (ibus_ren) begin
                        if (m_dir != 1'b1 || q_ibr.size() == 0) begin
                            fail("ibus_read_unexpected");
                        end else begin
                            chk("ibus_radr", ibus_radr, q_ibr[0]);
                            ia    = q_ibr.pop_front();
                            nxt_n = 4;
                        end
                    end
                end
                idle_now = !m_busy && !done_now;
                busy_nx  = m_busy && !last;
                done_nx  = last;
                if (start && idle_now) begin
                    if (len == 14'd0) begin
                        done_nx = 1'b1;
                    end else begin
                        busy_nx = 1'b1;
                        m_dir   = dir;
                        q_ibw_a.delete();
                        q_ibw_d.delete();
                        q_mrd.delete();
                        q_ibr.delete();
                        q_mw_a.delete();
                        q_mw_d.delete();
                        for (int i = 0; i < int'(len); i++) begin
                            ia = ibus_base + 14'(i);
                            ma = mem_base + 16'(i);
                            if (dir == 1'b0) begin
                                q_mrd.push_back(ma);
                                q_ibw_a.push_back(ia);
                                q_ibw_d.push_back(mem_a[ma]);
                            end else begin
                                q_ibr.push_back(ia);
                                q_mw_a.push_back(ma);
                                q_mw_d.push_back(ibuf_a[ia]);
                            end
                        end
                        nxt_n = dir ? 3 : 2;
                    end
                end
                m_busy   = busy_nx;
                done_now = done_nx;
                nxt      = nxt_n;
            end
        end
    end

    task automatic run_xfer(input logic d, input logic [13:0] ib,
                            input logic [15:0] mb, input logic [13:0] n,
                            input int lat, input bit mid);
        @(posedge clk);
        #1;
        fixed_lat  = lat;
        done_cnt   = 0;
        busy_cnt   = 0;
        ren_cnt    = 0;
        strobe_cnt = 0;
        dir        = d;
        ibus_base  = ib;
        mem_base   = mb;
        len        = n;
        start      = 1'b1;
        for (int c = 0; c < 5000 && done_cnt == 0; c++) begin
            @(posedge clk);
            #1;
            start = mid && (c == 4);
            if (start) begin
                ibus_base = ib + 14'h0100;
                mem_base  = mb + 16'h0100;
                len       = n + 14'd3;
            end
        end
        if (done_cnt == 0) fail("xfer_timeout");
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 65536; i++) mem_a[i] = 16'($urandom);
        for (int i = 0; i < 16384; i++) ibuf_a[i] = 16'($urandom);
        rst       = 1'b1;
        start     = 1'b0;
        dir       = 1'b0;
        ibus_base = '0;
        mem_base  = '0;
        len       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // LOAD of 4 words, ack on the third request cycle
        for (int i = 0; i < 4; i++) mem_a[16'h0100 + 16'(i)] = 16'hA000 + 16'(i);
        run_xfer(1'b0, 14'h0010, 16'h0100, 14'd4, 3, 1'b0);
        chk("load_done_count", done_cnt, 1);
        chk("load_busy_cycles", busy_cnt, 16);
        chk("load_buf0", ibuf_a[14'h0010], 16'hA000);
        chk("load_buf1", ibuf_a[14'h0011], 16'hA001);
        chk("load_buf2", ibuf_a[14'h0012], 16'hA002);
        chk("load_buf3", ibuf_a[14'h0013], 16'hA003);

        // STORE of 3 preloaded words, single-cycle memory
        ibuf_a[14'h0020] = 16'h1111;
        ibuf_a[14'h0021] = 16'h2222;
        ibuf_a[14'h0022] = 16'h3333;
        run_xfer(1'b1, 14'h0020, 16'h0200, 14'd3, 1, 1'b0);
        chk("store_done_count", done_cnt, 1);
        chk("store_busy_cycles", busy_cnt, 9);
        chk("store_ren_count", ren_cnt, 3);
        chk("store_mem0", mem_a[16'h0200], 16'h1111);
        chk("store_mem1", mem_a[16'h0201], 16'h2222);
        chk("store_mem2", mem_a[16'h0202], 16'h3333);

        // zero-length command
        run_xfer(1'b0, 14'h0123, 16'h4567, 14'd0, 2, 1'b0);
        chk("len0_done_count", done_cnt, 1);
        chk("len0_busy_cycles", busy_cnt, 0);
        chk("len0_strobes", strobe_cnt, 0);

        // ibus pointer wrap
        for (int i = 0; i < 3; i++) mem_a[16'h0300 + 16'(i)] = 16'hB000 + 16'(i);
        run_xfer(1'b0, 14'h3FFE, 16'h0300, 14'd3, 2, 1'b0);
        chk("wrap_buf3ffe", ibuf_a[14'h3FFE], 16'hB000);
        chk("wrap_buf3fff", ibuf_a[14'h3FFF], 16'hB001);
        chk("wrap_buf0000", ibuf_a[14'h0000], 16'hB002);

        // second start mid-LOAD must be ignored
        for (int i = 0; i < 4; i++) mem_a[16'h0400 + 16'(i)] = 16'hC000 + 16'(i);
        ibuf_a[14'h0200] = 16'h5A5A;
        run_xfer(1'b0, 14'h0100, 16'h0400, 14'd4, 2, 1'b1);
        chk("mid_done_count", done_cnt, 1);
        chk("mid_busy_cycles", busy_cnt, 12);
        chk("mid_buf0", ibuf_a[14'h0100], 16'hC000);
        chk("mid_buf3", ibuf_a[14'h0103], 16'hC003);
        chk("mid_untouched", ibuf_a[14'h0200], 16'h5A5A);

        // reset during the second memory write of a 5-word STORE
        for (int i = 0; i < 5; i++) ibuf_a[14'h0040 + 14'(i)] = 16'hD000 + 16'(i);
        mem_a[16'h0600] = 16'h0000;
        mem_a[16'h0601] = 16'h0000;
        @(posedge clk);
        #1;
        fixed_lat = 3;
        done_cnt  = 0;
        ren_cnt   = 0;
        dir       = 1'b1;
        ibus_base = 14'h0040;
        mem_base  = 16'h0600;
        len       = 14'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk);
            #1;
            if (ren_cnt == 2 && mem_req && mem_we) got = 1'b1;
        end
        if (!got) fail("rst_window_timeout");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt, 0);
        chk("rst_word1_kept", mem_a[16'h0600], 16'hD000);
        chk("rst_word2_absent", mem_a[16'h0601], 16'h0000);

        // fresh STORE after reset, memory pointer wrapping
        for (int i = 0; i < 3; i++) ibuf_a[14'h0050 + 14'(i)] = 16'hE000 + 16'(i);
        run_xfer(1'b1, 14'h0050, 16'hFFFF, 14'd3, 2, 1'b0);
        chk("post_rst_done", done_cnt, 1);
        chk("post_rst_memffff", mem_a[16'hFFFF], 16'hE000);
        chk("post_rst_mem0000", mem_a[16'h0000], 16'hE001);
        chk("post_rst_mem0001", mem_a[16'h0001], 16'hE002);

        // randomized traffic with random latency and stray acks
        fixed_lat = 0;
        rand_ack  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            start     = ($urandom_range(0, 9) == 0);
            dir       = 1'($urandom);
            ibus_base = ($urandom_range(0, 3) == 0)
                        ? 14'h3FFC + 14'($urandom_range(0, 3))
                        : 14'($urandom);
            mem_base  = 16'($urandom);
            len       = 14'($urandom_range(0, 5));
        end
        start    = 1'b0;
        rand_ack = 1'b0;
        repeat (60) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibus_xfer_master.md
# ibus_xfer_master

Bus-master transfer engine for the systolic array's buffer-RAM port (`ibus_*`). It is the initiator for the interface the systolic top exposes as a target. In LOAD it moves operand words from system memory into the A/B buffers. In STORE it drains result words from the buffers back to system memory. It is programmed by a single start pulse carrying base addresses, a word count and a direction. It runs one word at a time through a small FSM.

## Interface
Parameters:
- `MEM_AW`, default 16: system-memory word-address width.
- `CNT_W`, default 14: width of the transfer length field; a transfer covers at most the full ibus window.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  one-cycle command pulse.
- `dir`  in  1  0 = LOAD (memory to ibus), 1 = STORE (ibus to memory); sampled on `start`.
- `ibus_base`  in  14  first ibus word address, bits [15:2]; sampled on `start`.
- `mem_base`  in  MEM_AW  first memory word address; sampled on `start`.
- `len`  in  CNT_W  number of 16-bit words; sampled on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `ibus_ren`  out  1  ibus read strobe.
- `ibus_radr`  out  14  ibus read address.
- `ibus_rdata`  in  16  ibus read data, valid exactly 1 cycle after `ibus_ren`.
- `ibus_wen`  out  1  ibus write strobe.
- `ibus_wadr`  out  14  ibus write address.
- `ibus_wdata`  out  16  ibus write data.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req` is high.
- `mem_adr`  out  MEM_AW  memory word address; stable while `mem_req` is high.
- `mem_wdata`  out  16  memory write data; stable while `mem_req` is high.
- `mem_rdata`  in  16  memory read data, valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle completion of the current request.

## Operation
- Reset value of every output is 0, and the FSM is in IDLE.
- FSM states: IDLE, MRD, IBWR, IBRD, IBCAP, MWR, FIN.
- IDLE accepts `start` and latches `dir`, both bases and `len` into the pointers and the remaining-count register.
  - If `len`==0, go to FIN.
  - Else LOAD goes to MRD and STORE goes to IBRD.
- `start` is ignored while `busy` is high or while in FIN.
- LOAD loop:
  - MRD: `mem_req`=1, `mem_we`=0. On `mem_ack`, capture `mem_rdata` and go to IBWR.
  - IBWR: `ibus_wen`=1 for exactly one cycle with the current ibus pointer and the captured data. Then increment both pointers and decrement the count. If the count reaches 0, go to FIN, else go to MRD.
- STORE loop:
  - IBRD: `ibus_ren`=1 for one cycle.
  - IBCAP: capture `ibus_rdata`.
  - MWR: `mem_req`=1, `mem_we`=1 with the captured data. On `mem_ack`, increment the pointers and decrement the count. If the count reaches 0, go to FIN, else go to IBRD.
- FIN: `done`=1 for one cycle, `busy` goes to 0, return to IDLE.
- Arithmetic and address rules:
  - The ibus pointer increments modulo 2^14 and wraps 0x3FFF to 0x0000 silently.
  - The memory pointer increments modulo 2^MEM_AW.
  - The count is unsigned; `len`=2^CNT_W−1 is legal.
- `mem_ack` is honoured only while `mem_req` is high and is ignored otherwise.
- `ibus_ren` and `ibus_wen` are never high in the same cycle.
- Reset asserted mid-transfer: on the next edge all outputs go to 0, the FSM returns to IDLE and no `done` is issued. A partially written buffer is left as is.

## Timing
- Accepted `start` at cycle t: `busy`=1 from t+1. The first `mem_req` (LOAD) or `ibus_ren` (STORE) is also at t+1.
- LOAD, per word: (memory latency k ≥ 1 cycles of `mem_req` up to and including `ack`) + 1 IBWR cycle.
- STORE, per word: 2 cycles (IBRD, IBCAP) + k.
- `done` is asserted one cycle after the last IBWR, or after the last `mem_ack` cycle.
- `len`=0: `done` at t+1 with no bus activity, and `busy` stays low.
- All outputs are registered. There are no combinational paths from `mem_ack` or `ibus_rdata` to outputs.

## Structure
- Shared package `sys_pkg`:
  - FSM state enum.
  - `IBUS_AW`=14.
  - `DATA_W`=16.
  - Direction constants `DIR_LOAD`/`DIR_STORE`.
- Single flat module. A natural sub-module is `xfer_addr_gen`: two pointers plus the down-counter, with load, step and a last flag. It is reused by the result-drain path.

## Test plan
- LOAD `ibus_base`=0x0010, `mem_base`=0x0100, `len`=4, memory returns 0xA000+i with `ack` 2 cycles after `req`:
  - ibus writes occur at 0x0010..0x0013 with data 0xA000..0xA003.
  - `done` is asserted once and `busy` spans the whole transfer.
- STORE `ibus_base`=0x0020, `len`=3, buffer preloaded with 0x1111/0x2222/0x3333:
  - memory writes occur at `mem_base`..+2 with identical data.
  - `ibus_ren` is observed 3 times, and it is never high together with `ibus_wen`.
- `len`=0: `done` at t+1, `busy` never high, no `mem_req`, `ibus_ren` or `ibus_wen`.
- Wrap: `ibus_base`=0x3FFE, `len`=3, LOAD: write addresses are 0x3FFE, 0x3FFF, 0x0000.
- `start` pulsed again mid-LOAD with different bases: it is ignored, and the original addresses and count complete unchanged.
- `rst` asserted during MWR of word 2 of 5: all outputs are 0 on the next edge, no `done`. A new STORE started afterwards completes correctly.
